// File: rtl/sync_mem_arbiter_pkg.sv
// Shared types and default sizes for the two-port sync memory arbiter.
// Holds requester index width, default geometry and tracking struct.
package sync_mem_arbiter_pkg;

  localparam int IDX_W      = 1;
  localparam int AWIDTH_DEF = 10;
  localparam int DWIDTH_DEF = 32;
  localparam int DEPTH_DEF  = 1 << AWIDTH_DEF;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic pending;
    idx_t tag;
  } rsp_trk_t;

endpackage

// File: rtl/sync_mem_arbiter_if.sv
// Bundle of both requester handshakes and the memory-side port.
// slave: arbiter view; master: requesters plus memory view.
interface sync_mem_arbiter_if
  import sync_mem_arbiter_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) ();

  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [AWIDTH-1:0] req0_addr;
  logic [DWIDTH-1:0] req0_wdata;
  logic              resp0_valid;
  logic [DWIDTH-1:0] resp0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH-1:0] req1_wdata;
  logic              resp1_valid;
  logic [DWIDTH-1:0] resp1_data;

  logic              mem_en;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_din;
  logic [DWIDTH-1:0] mem_dout;

  modport slave (
    input  req0_valid, req0_we,
    input  req0_addr, req0_wdata,
    input  req1_valid, req1_we,
    input  req1_addr, req1_wdata,
    input  mem_dout,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_data,
    output resp1_valid, resp1_data,
    output mem_en, mem_we,
    output mem_addr, mem_din
  );

  modport master (
    output req0_valid, req0_we,
    output req0_addr, req0_wdata,
    output req1_valid, req1_we,
    output req1_addr, req1_wdata,
    output mem_dout,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_data,
    input  resp1_valid, resp1_data,
    input  mem_en, mem_we,
    input  mem_addr, mem_din
  );

endinterface

// File: rtl/sync_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant; last_grant remembers the previous winner.
// Ports: clk, reset_n, valid[1:0] in; one-hot gnt and gnt_idx out.
module rr_arb2
  import sync_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  output logic [1:0] gnt,
  output idx_t       gnt_idx
);

  idx_t last_grant;
  logic both;
  logic only0;
  logic only1;

  assign both  = valid[0] & valid[1];
  assign only0 = valid[0] & ~valid[1];
  assign only1 = valid[1] & ~valid[0];

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      both:    gnt = last_grant[0] ? 2'b01 : 2'b10;
      only0:   gnt = 2'b01;
      only1:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign gnt_idx = idx_t'(gnt[1]);

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= idx_t'(1);
    end else if (|gnt) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/sync_mem_arbiter.sv
// Arbitrates two requesters onto one sync-read memory port.
// Ports: clk, reset_n, bus (slave: requests, responses, memory side).
module sync_mem_arbiter
  import sync_mem_arbiter_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  sync_mem_arbiter_if.slave   bus
);

  logic [1:0]               valid;
  logic [1:0]               gnt;
  idx_t                     gnt_idx;
  logic                     sel_we;
  logic [$clog2(DEPTH)-1:0] sel_addr;
  logic [DWIDTH-1:0]        sel_wdata;
  logic                     acc;
  logic                     acc_rd;
  rsp_trk_t                 trk;

  assign valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  always_comb begin
    sel_we    = bus.req0_we;
    sel_addr  = bus.req0_addr;
    sel_wdata = bus.req0_wdata;
    if (gnt_idx[0]) begin
      sel_we    = bus.req1_we;
      sel_addr  = bus.req1_addr;
      sel_wdata = bus.req1_wdata;
    end
  end

  assign acc    = |gnt;
  assign acc_rd = acc & ~sel_we;

  assign bus.mem_en   = acc;
  assign bus.mem_we   = acc & sel_we;
  assign bus.mem_addr = sel_addr;
  assign bus.mem_din  = sel_wdata;

  // Read data arrives one cycle after the access; the tag
  // steers it back to whoever issued the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trk <= '0;
    end else begin
      trk.pending <= acc_rd;
      trk.tag     <= gnt_idx;
    end
  end

  assign bus.resp0_valid = trk.pending & ~trk.tag[0];
  assign bus.resp1_valid = trk.pending & trk.tag[0];
  assign bus.resp0_data  = bus.mem_dout;
  assign bus.resp1_data  = bus.mem_dout;

endmodule
